// File: rtl/mul8_pkg.sv
// Shared types and constants for the sequential 8-bit shift-add multiplier.
package mul8_pkg;

   localparam int MUL8_WIDTH = 8;
   localparam int MUL8_CNT_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul8_state_t;

endpackage

// File: rtl/mul8_seq_unit_if.sv
// Request/result bundle between the sequencing controller (master) and the multiplier (slave).
interface mul8_seq_unit_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             ovf;

   modport master (output start, a, b, input busy, done, result, ovf);
   modport slave  (input start, a, b, output busy, done, result, ovf);
endinterface

// File: rtl/mul8_shift_acc.sv
// Shift-add datapath: multiplicand/multiplier shift registers and 2*WIDTH accumulator.
module mul8_shift_acc
   import mul8_pkg::*;
#(
   parameter int WIDTH = MUL8_WIDTH
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               init,
   input  logic               step,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] prod_next
);

   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   mplier;

   // Accumulator value after the current step; on the last step this is the full product.
   assign prod_next = acc + (mplier[0] ? mcand : '0);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
      end else if (init) begin
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
         acc    <= '0;
      end else if (step) begin
         acc    <= prod_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end

endmodule

// File: rtl/mul8_seq_unit.sv
// Sequential unsigned multiplier top: FSM, iteration counter and registered outputs.
// Build option: define MUL8_SAT_EN to saturate result to all-ones on overflow.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one partial-product iteration per clock, WIDTH iterations
// DONE  | one-cycle done strobe with result/ovf valid
module mul8_seq_unit
   import mul8_pkg::*;
#(
   parameter int WIDTH = MUL8_WIDTH
) (
   input  logic           clock,
   input  logic           reset_n,
   mul8_seq_unit_if.slave bus
);

   localparam logic [MUL8_CNT_W-1:0] CNT_LAST = MUL8_CNT_W'(WIDTH - 1);

   mul8_state_t             state;
   logic [MUL8_CNT_W-1:0]   cnt;
   logic                    busy_q;
   logic                    done_q;
   logic                    ovf_q;
   logic [WIDTH-1:0]        result_q;
   logic                    init;
   logic                    step;
   logic [2*WIDTH-1:0]      prod_next;
   logic                    ovf_next;
   logic [WIDTH-1:0]        result_next;

   assign init = (state == IDLE) && bus.start;
   assign step = (state == RUN);

   mul8_shift_acc #(.WIDTH(WIDTH)) u_shift_acc (
      .clock     (clock),
      .reset_n   (reset_n),
      .init      (init),
      .step      (step),
      .a         (bus.a),
      .b         (bus.b),
      .prod_next (prod_next)
   );

   assign ovf_next = |prod_next[2*WIDTH-1:WIDTH];

`ifdef MUL8_SAT_EN
   assign result_next = ovf_next ? {WIDTH{1'b1}} : prod_next[WIDTH-1:0];
`else
   assign result_next = prod_next[WIDTH-1:0];
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         result_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state  <= RUN;
                  cnt    <= '0;
                  busy_q <= 1'b1;
               end
            end
            RUN: begin
               cnt <= cnt + 1'b1;
               // No early exit on a zero multiplier: latency is fixed at WIDTH iterations.
               if (cnt == CNT_LAST) begin
                  state    <= DONE;
                  done_q   <= 1'b1;
                  ovf_q    <= ovf_next;
                  result_q <= result_next;
               end
            end
            DONE: begin
               state  <= IDLE;
               done_q <= 1'b0;
               busy_q <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               done_q <= 1'b0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.ovf    = ovf_q;
   assign bus.result = result_q;

endmodule

// File: tb/tb_mul8_seq_unit.sv
// Scoreboard bench for mul8_seq_unit: a cycle-counting reference model queues expected products, a monitor checks outputs.
module tb_mul8_seq_unit;
   import mul8_pkg::*;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   mul8_seq_unit_if #(.WIDTH(MUL8_WIDTH)) bus ();

   mul8_seq_unit #(.WIDTH(MUL8_WIDTH)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clock = ~clock;

   typedef struct {
      int res;
      int ovf;
      int due;
      bit dead;
   } exp_t;

   exp_t exp_q[$];
   int   cyc     = 0;
   int   c0      = 0;
   int   free_at = 0;
   bit   active  = 1'b0;

   int   checks  = 0;
   int   errors  = 0;
   int   rd      = 0;
   int   last_res = 0;
   int   last_ovf = 0;

   function automatic exp_t model_mul(int a, int b, int start_cyc);
      exp_t e;
      int   p;
      p      = a * b;
      e.ovf  = (p > 255) ? 1 : 0;
`ifdef MUL8_SAT_EN
      e.res  = e.ovf ? 255 : (p % 256);
`else
      e.res  = p % 256;
`endif
      e.due  = start_cyc + 8;
      e.dead = 1'b0;
      return e;
   endfunction

   // Reference model: an operation is accepted when start is seen and at least 10 cycles
   // have elapsed since the previous acceptance; its result appears 8 cycles later.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         foreach (exp_q[i])
            if (exp_q[i].due > cyc) exp_q[i].dead = 1'b1;
         active  = 1'b0;
         free_at = 0;
      end else begin
         cyc++;
         if (bus.start && cyc >= free_at) begin
            exp_q.push_back(model_mul(int'(bus.a), int'(bus.b), cyc));
            c0      = cyc;
            free_at = cyc + 10;
            active  = 1'b1;
         end
      end
   end

   task automatic chk(string name, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, req, cyc, $time);
      end
   endtask

   always begin
      @(negedge clock or negedge reset_n);
      #1;
      if (!reset_n) begin
         chk("rst_busy",   int'(bus.busy),   0);
         chk("rst_done",   int'(bus.done),   0);
         chk("rst_result", int'(bus.result), 0);
         chk("rst_ovf",    int'(bus.ovf),    0);
         last_res = 0;
         last_ovf = 0;
      end else begin
         int bexp;
         int dexp;
         bexp = (active && cyc >= c0 && cyc <= c0 + 8) ? 1 : 0;
         dexp = (active && cyc == c0 + 8) ? 1 : 0;
         chk("busy", int'(bus.busy), bexp);
         chk("done", int'(bus.done), dexp);
         if (bus.done) begin
            while (rd < exp_q.size() && exp_q[rd].dead) rd++;
            chk("done_has_entry", (rd < exp_q.size()) ? 1 : 0, 1);
            if (rd < exp_q.size()) begin
               chk("result",  int'(bus.result), exp_q[rd].res);
               chk("ovf",     int'(bus.ovf),    exp_q[rd].ovf);
               chk("latency", cyc,              exp_q[rd].due);
               last_res = exp_q[rd].res;
               last_ovf = exp_q[rd].ovf;
               rd++;
            end
         end else begin
            chk("result_hold", int'(bus.result), last_res);
            chk("ovf_hold",    int'(bus.ovf),    last_ovf);
         end
      end
   end

   // Drive start for the next edge (E0), then scramble operands after capture.
   task automatic start_op(logic [7:0] a, logic [7:0] b);
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
      bus.a     = 8'($urandom);
      bus.b     = 8'($urandom);
   endtask

   task automatic do_op(logic [7:0] a, logic [7:0] b);
      start_op(a, b);
      repeat (9) @(negedge clock);
   endtask

   task automatic pulse(logic [7:0] a, logic [7:0] b);
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
   endtask

   initial begin
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(negedge clock);
      #2 reset_n = 1'b1;
      @(negedge clock);

      do_op(8'h0C, 8'h0A);
      repeat (2) @(negedge clock);
      do_op(8'h10, 8'h10);
      do_op(8'hFF, 8'hFF);
      do_op(8'h00, 8'h37);

      // Start attempts during RUN (E4) and DONE (E9) must be ignored.
      start_op(8'h03, 8'h05);
      repeat (3) @(negedge clock);
      pulse(8'h02, 8'h02);
      repeat (4) @(negedge clock);
      pulse(8'h02, 8'h02);
      repeat (4) @(negedge clock);

      // Reset mid-RUN, after E5.
      start_op(8'h07, 8'h09);
      repeat (5) @(negedge clock);
      #2 reset_n = 1'b0;
      repeat (2) @(negedge clock);
      #2 reset_n = 1'b1;
      @(negedge clock);
      do_op(8'h02, 8'h03);
      repeat (2) @(negedge clock);

      // Start held high: back-to-back operations every 10 cycles.
      bus.a     = 8'h04;
      bus.b     = 8'h04;
      bus.start = 1'b1;
      repeat (35) @(negedge clock);
      bus.start = 1'b0;
      repeat (10) @(negedge clock);

      // Random operands with random start noise while busy.
      for (int n = 0; n < 30; n++) begin
         start_op(8'($urandom), 8'($urandom));
         for (int k = 0; k < 9; k++) begin
            @(negedge clock);
            bus.start = ($urandom_range(0, 3) == 0);
            bus.a     = 8'($urandom);
            bus.b     = 8'($urandom);
         end
         bus.start = 1'b0;
         repeat ($urandom_range(0, 3)) @(negedge clock);
      end

      repeat (5) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
